// File: rtl/csr_ctrl_pkg.sv
// Shared types and constants for the machine-mode CSR sequencing controller.
// Covers op encodings, CSR address map, mstatus field positions and FSM states.
package csr_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd1,
        OP_CSRRS = 3'd2,
        OP_CSRRC = 3'd3,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_VEC,
        ST_RESP
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [2:0] IDX_MSTATUS = 3'd0;
    localparam logic [2:0] IDX_MTVEC   = 3'd1;
    localparam logic [2:0] IDX_MEPC    = 3'd2;
    localparam logic [2:0] IDX_MCAUSE  = 3'd3;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_HI   = 12;
    localparam int MPP_LO   = 11;

    localparam logic [3:0] CAUSE_ECALL = 4'd11;

    // Trap entry stacks MIE into MPIE and forces machine mode as previous privilege.
    function automatic logic [63:0] mstatus_trap(input logic [63:0] old);
        logic [63:0] v;
        v                = old;
        v[MPIE_BIT]      = old[MIE_BIT];
        v[MIE_BIT]       = 1'b0;
        v[MPP_HI:MPP_LO] = 2'b11;
        return v;
    endfunction

    function automatic logic [63:0] mstatus_ret(input logic [63:0] old);
        logic [63:0] v;
        v                = old;
        v[MIE_BIT]       = old[MPIE_BIT];
        v[MPIE_BIT]      = 1'b1;
        v[MPP_HI:MPP_LO] = 2'b11;
        return v;
    endfunction

endpackage

// File: rtl/csr_ctrl_if.sv
// Request/response channel between the execute stage (master) and csr_ctrl (slave).
interface csr_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_csr;
    logic [63:0] req_src;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_redirect;
    logic [63:0] resp_target;
    logic        resp_illegal;

    modport master (
        output req_valid, req_op, req_csr, req_src, req_pc, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_redirect, resp_target, resp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_csr, req_src, req_pc, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_redirect, resp_target, resp_illegal
    );

endinterface

// File: rtl/csr_ctrl_addr_decode.sv
// Maps a 12-bit CSR address onto the 3-bit file index; unmapped addresses are flagged illegal.
module csr_addr_decode
    import csr_ctrl_pkg::*;
(
    input  logic [11:0] addr,
    output logic        legal,
    output logic [2:0]  idx
);

    always_comb begin
        legal = 1'b0;
        idx   = IDX_MSTATUS;
        case (addr)
            CSR_MSTATUS: begin legal = 1'b1; idx = IDX_MSTATUS; end
            CSR_MTVEC:   begin legal = 1'b1; idx = IDX_MTVEC;   end
            CSR_MEPC:    begin legal = 1'b1; idx = IDX_MEPC;    end
            CSR_MCAUSE:  begin legal = 1'b1; idx = IDX_MCAUSE;  end
            default:     begin legal = 1'b0; idx = IDX_MSTATUS; end
        endcase
    end

endmodule

// File: rtl/csr_ctrl.sv
// Sequences CSR read-modify-write, ECALL and MRET over the single-ported CSR file.
// Sole writer of the file: write port and exception-capture port are both driven here.
module csr_ctrl
    import csr_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    csr_ctrl_if.slave   bus,
    output logic [2:0]  csr_raddr,
    input  logic [63:0] csr_rdata,
    output logic        csr_wen,
    output logic [2:0]  csr_waddr,
    output logic [63:0] csr_wdata,
    output logic        exc_valid,
    output logic [63:0] exc_epc,
    output logic [3:0]  exc_no
);

    state_e      state;
    state_e      state_next;
    logic [2:0]  op_q;
    logic [11:0] csr_q;
    logic [63:0] src_q;
    logic [63:0] pc_q;
    logic        addr_legal;
    logic [2:0]  addr_idx;
    logic        is_csr_op;
    logic        is_legal;

    csr_addr_decode u_decode (
        .addr  (csr_q),
        .legal (addr_legal),
        .idx   (addr_idx)
    );

    assign is_csr_op = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);
    assign is_legal  = (is_csr_op && addr_legal) || (op_q == OP_ECALL) || (op_q == OP_MRET);

    assign bus.req_ready  = reset && (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);

    always_ff @(posedge clock) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Write strobes are gated by reset so a reset landing in EXEC drops that cycle's write.
    always_comb begin
        state_next = state;
        csr_raddr  = IDX_MSTATUS;
        csr_wen    = 1'b0;
        csr_waddr  = IDX_MSTATUS;
        csr_wdata  = '0;
        exc_valid  = 1'b0;
        exc_epc    = '0;
        exc_no     = '0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (!is_legal) begin
                    state_next = ST_RESP;
                end else if (is_csr_op) begin
                    csr_raddr = addr_idx;
                    csr_waddr = addr_idx;
                    case (op_q)
                        OP_CSRRS: csr_wdata = csr_rdata | src_q;
                        OP_CSRRC: csr_wdata = csr_rdata & ~src_q;
                        default:  csr_wdata = src_q;
                    endcase
                    csr_wen    = reset && ((op_q == OP_CSRRW) || (src_q != '0));
                    state_next = ST_RESP;
                end else begin
                    csr_wdata  = (op_q == OP_ECALL) ? mstatus_trap(csr_rdata) : mstatus_ret(csr_rdata);
                    csr_wen    = reset;
                    exc_valid  = reset && (op_q == OP_ECALL);
                    exc_epc    = pc_q;
                    exc_no     = CAUSE_ECALL;
                    state_next = ST_VEC;
                end
            end
            ST_VEC: begin
                csr_raddr  = (op_q == OP_ECALL) ? IDX_MTVEC : IDX_MEPC;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q              <= '0;
            csr_q             <= '0;
            src_q             <= '0;
            pc_q              <= '0;
            bus.resp_rdata    <= '0;
            bus.resp_redirect <= 1'b0;
            bus.resp_target   <= '0;
            bus.resp_illegal  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.req_op;
                        csr_q <= bus.req_csr;
                        src_q <= bus.req_src;
                        pc_q  <= bus.req_pc;
                    end
                end
                ST_EXEC: begin
                    if (!is_legal)      bus.resp_illegal <= 1'b1;
                    else if (is_csr_op) bus.resp_rdata   <= csr_rdata;
                end
                ST_VEC: begin
                    bus.resp_redirect <= 1'b1;
                    bus.resp_target   <= (op_q == OP_ECALL) ? {csr_rdata[63:2], 2'b00} : csr_rdata;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_rdata    <= '0;
                        bus.resp_redirect <= 1'b0;
                        bus.resp_target   <= '0;
                        bus.resp_illegal  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl with a behavioural 4-entry CSR file attached to its ports.
module tb_csr_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  csr_raddr;
    logic [63:0] csr_rdata;
    logic        csr_wen;
    logic [2:0]  csr_waddr;
    logic [63:0] csr_wdata;
    logic        exc_valid;
    logic [63:0] exc_epc;
    logic [3:0]  exc_no;

    logic [63:0] csr_file [4] = '{default: 64'h0};
    int          wen_count = 0;
    int          exc_count = 0;
    int          total = 0;
    int          bad = 0;

    csr_ctrl_if bus ();

    csr_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .csr_raddr (csr_raddr),
        .csr_rdata (csr_rdata),
        .csr_wen   (csr_wen),
        .csr_waddr (csr_waddr),
        .csr_wdata (csr_wdata),
        .exc_valid (exc_valid),
        .exc_epc   (exc_epc),
        .exc_no    (exc_no)
    );

    always #5 clock = ~clock;

    // CSR file model: combinational read, write port plus exception capture into mepc/mcause.
    assign csr_rdata = (csr_raddr < 3'd4) ? csr_file[csr_raddr[1:0]] : 64'h0;

    always @(posedge clock) begin
        if (csr_wen) begin
            csr_file[csr_waddr[1:0]] <= csr_wdata;
            wen_count <= wen_count + 1;
        end
        if (exc_valid) begin
            csr_file[2] <= exc_epc;
            csr_file[3] <= {60'h0, exc_no};
            exc_count <= exc_count + 1;
        end
    end

    // Presents one request for a single accept edge; returns at the negedge of the EXEC cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [11:0] csr,
                                 input logic [63:0] src, input logic [63:0] pc);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_csr   = csr;
        bus.req_src   = src;
        bus.req_pc    = pc;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic finishResp();
        bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        total++; if ({bus.resp_redirect, bus.resp_illegal} !== 2'b00) begin bad++; $display("[TB] FAIL reset_flags: got %b want 00", {bus.resp_redirect, bus.resp_illegal}); end
        total++; if (bus.resp_rdata !== 64'h0 || bus.resp_target !== 64'h0) begin bad++; $display("[TB] FAIL reset_data: got %h/%h want 0/0", bus.resp_rdata, bus.resp_target); end
        total++; if ({csr_wen, exc_valid, csr_raddr} !== 5'b0) begin bad++; $display("[TB] FAIL reset_file_port: got %b want 00000", {csr_wen, exc_valid, csr_raddr}); end
    endtask

    task automatic test_csrrw();
        applyStimulus(3'd1, 12'h305, 64'h8000_0000, 64'h1000);
        total++; if (csr_wen !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rw_exec: got wen=%b valid=%b want 1/0", csr_wen, bus.resp_valid); end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rw_busy: got %b want 0", bus.req_ready); end
        @(negedge clock);
        total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rw_valid: got %b want 1", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 64'h0) begin bad++; $display("[TB] FAIL rw_rdata: got %h want 0", bus.resp_rdata); end
        total++; if (csr_file[1] !== 64'h8000_0000) begin bad++; $display("[TB] FAIL rw_mtvec: got %h want 80000000", csr_file[1]); end
        finishResp();
        total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rw_idle: got ready=%b valid=%b want 1/0", bus.req_ready, bus.resp_valid); end
        applyStimulus(3'd1, 12'h300, 64'ha_0000_1808, 64'h1004);
        @(negedge clock);
        total++; if (csr_file[0] !== 64'ha_0000_1808 || bus.resp_rdata !== 64'h0) begin bad++; $display("[TB] FAIL rw_mstatus: got %h rdata %h want a00001808/0", csr_file[0], bus.resp_rdata); end
        finishResp();
    endtask

    task automatic test_set_clear();
        int wen0;
        wen0 = wen_count;
        applyStimulus(3'd2, 12'h300, 64'h0, 64'h1008);
        total++; if (csr_wen !== 1'b0) begin bad++; $display("[TB] FAIL rs0_wen: got %b want 0", csr_wen); end
        @(negedge clock);
        total++; if (bus.resp_rdata !== 64'ha_0000_1808) begin bad++; $display("[TB] FAIL rs0_rdata: got %h want a00001808", bus.resp_rdata); end
        total++; if (wen_count != wen0 || csr_file[0] !== 64'ha_0000_1808) begin bad++; $display("[TB] FAIL rs0_nowrite: got writes=%0d mstatus=%h want 0/a00001808", wen_count - wen0, csr_file[0]); end
        finishResp();
        applyStimulus(3'd3, 12'h300, 64'h8, 64'h100c);
        @(negedge clock);
        total++; if (bus.resp_rdata !== 64'ha_0000_1808) begin bad++; $display("[TB] FAIL rc_rdata: got %h want a00001808", bus.resp_rdata); end
        total++; if (csr_file[0] !== 64'ha_0000_1800) begin bad++; $display("[TB] FAIL rc_mstatus: got %h want a00001800", csr_file[0]); end
        finishResp();
        applyStimulus(3'd2, 12'h300, 64'h8, 64'h1010);
        @(negedge clock);
        total++; if (bus.resp_rdata !== 64'ha_0000_1800 || csr_file[0] !== 64'ha_0000_1808) begin bad++; $display("[TB] FAIL rs_set: got rdata %h mstatus %h want a00001800/a00001808", bus.resp_rdata, csr_file[0]); end
        finishResp();
        applyStimulus(3'd1, 12'h305, 64'h8000_0203, 64'h1014);
        @(negedge clock);
        total++; if (bus.resp_rdata !== 64'h8000_0000 || csr_file[1] !== 64'h8000_0203) begin bad++; $display("[TB] FAIL rw_mtvec2: got rdata %h mtvec %h want 80000000/80000203", bus.resp_rdata, csr_file[1]); end
        finishResp();
    endtask

    task automatic test_ecall();
        applyStimulus(3'd4, 12'h000, 64'h0, 64'h8000_0100);
        total++; if (exc_valid !== 1'b1 || csr_wen !== 1'b1 || csr_waddr !== 3'd0) begin bad++; $display("[TB] FAIL ecall_exec: got exc=%b wen=%b waddr=%0d want 1/1/0", exc_valid, csr_wen, csr_waddr); end
        @(negedge clock);
        total++; if (csr_file[2] !== 64'h8000_0100 || csr_file[3] !== 64'd11) begin bad++; $display("[TB] FAIL ecall_capture: got mepc %h mcause %h want 80000100/b", csr_file[2], csr_file[3]); end
        total++; if (csr_file[0] !== 64'ha_0000_1880) begin bad++; $display("[TB] FAIL ecall_mstatus: got %h want a00001880", csr_file[0]); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL ecall_early: got valid %b want 0", bus.resp_valid); end
        @(negedge clock);
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_redirect !== 1'b1) begin bad++; $display("[TB] FAIL ecall_resp: got valid=%b redirect=%b want 1/1", bus.resp_valid, bus.resp_redirect); end
        total++; if (bus.resp_target !== 64'h8000_0200 || bus.resp_rdata !== 64'h0) begin bad++; $display("[TB] FAIL ecall_target: got %h rdata %h want 80000200/0", bus.resp_target, bus.resp_rdata); end
        finishResp();
    endtask

    task automatic test_mret();
        int exc0;
        applyStimulus(3'd1, 12'h341, 64'h8000_0104, 64'h2000);
        @(negedge clock);
        total++; if (bus.resp_rdata !== 64'h8000_0100) begin bad++; $display("[TB] FAIL mepc_rdata: got %h want 80000100", bus.resp_rdata); end
        finishResp();
        exc0 = exc_count;
        applyStimulus(3'd5, 12'h000, 64'h0, 64'h2004);
        @(negedge clock);
        total++; if (csr_file[0] !== 64'ha_0000_1888) begin bad++; $display("[TB] FAIL mret_mstatus: got %h want a00001888", csr_file[0]); end
        @(negedge clock);
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_redirect !== 1'b1 || bus.resp_target !== 64'h8000_0104) begin bad++; $display("[TB] FAIL mret_resp: got valid=%b redirect=%b target=%h want 1/1/80000104", bus.resp_valid, bus.resp_redirect, bus.resp_target); end
        total++; if (exc_count != exc0) begin bad++; $display("[TB] FAIL mret_noexc: got %0d captures want 0", exc_count - exc0); end
        finishResp();
    endtask

    task automatic test_illegal();
        int wen0;
        int exc0;
        logic [63:0] snap [4];
        wen0 = wen_count;
        exc0 = exc_count;
        snap = csr_file;
        applyStimulus(3'd1, 12'h123, 64'hdead_beef, 64'h3000);
        @(negedge clock);
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_illegal !== 1'b1 || bus.resp_rdata !== 64'h0) begin bad++; $display("[TB] FAIL ill_addr: got valid=%b illegal=%b rdata=%h want 1/1/0", bus.resp_valid, bus.resp_illegal, bus.resp_rdata); end
        finishResp();
        applyStimulus(3'd7, 12'h300, 64'hffff, 64'h3004);
        @(negedge clock);
        total++; if (bus.resp_illegal !== 1'b1 || bus.resp_redirect !== 1'b0) begin bad++; $display("[TB] FAIL ill_op: got illegal=%b redirect=%b want 1/0", bus.resp_illegal, bus.resp_redirect); end
        finishResp();
        total++; if (wen_count != wen0 || exc_count != exc0) begin bad++; $display("[TB] FAIL ill_writes: got wen=%0d exc=%0d want 0/0", wen_count - wen0, exc_count - exc0); end
        total++; if (csr_file != snap) begin bad++; $display("[TB] FAIL ill_state: got %h %h %h %h want unchanged", csr_file[0], csr_file[1], csr_file[2], csr_file[3]); end
    endtask

    task automatic test_backpressure();
        int held_bad;
        held_bad = 0;
        applyStimulus(3'd1, 12'h342, 64'h5, 64'h4000);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_rdata !== 64'd11 ||
                bus.resp_illegal !== 1'b0 || bus.resp_redirect !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d: got valid=%b ready=%b rdata=%h want 1/0/b", i, bus.resp_valid, bus.req_ready, bus.resp_rdata);
            end
            @(negedge clock);
        end
        total++; if (csr_file[3] !== 64'd5) begin bad++; $display("[TB] FAIL bp_mcause: got %h want 5", csr_file[3]); end
        finishResp();
        total++; if (bus.req_ready !== 1'b1 || bus.resp_rdata !== 64'h0) begin bad++; $display("[TB] FAIL bp_release: got ready=%b rdata=%h want 1/0", bus.req_ready, bus.resp_rdata); end
    endtask

    task automatic test_reset_midflight();
        applyStimulus(3'd1, 12'h305, 64'h1234, 64'h5000);
        reset = 1'b0;
        #1;
        total++; if (csr_wen !== 1'b0) begin bad++; $display("[TB] FAIL rst_exec_wen: got %b want 0", csr_wen); end
        @(negedge clock);
        total++; if (csr_file[1] !== 64'h8000_0203 || bus.resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_exec: got mtvec=%h valid=%b want 80000203/0", csr_file[1], bus.resp_valid); end
        reset = 1'b1;
        @(negedge clock);
        applyStimulus(3'd4, 12'h000, 64'h0, 64'h8000_0300);
        @(negedge clock);
        total++; if (csr_file[2] !== 64'h8000_0300 || csr_file[0] !== 64'ha_0000_1880) begin bad++; $display("[TB] FAIL rst_vec_commit: got mepc=%h mstatus=%h want 80000300/a00001880", csr_file[2], csr_file[0]); end
        reset = 1'b0;
        @(negedge clock);
        total++; if (bus.resp_valid !== 1'b0 || bus.resp_redirect !== 1'b0 || bus.resp_target !== 64'h0) begin bad++; $display("[TB] FAIL rst_vec: got valid=%b redirect=%b target=%h want 0/0/0", bus.resp_valid, bus.resp_redirect, bus.resp_target); end
        reset = 1'b1;
        @(negedge clock);
        total++; if (bus.req_ready !== 1'b1 || csr_file[2] !== 64'h8000_0300 || csr_file[3] !== 64'd11) begin bad++; $display("[TB] FAIL rst_after: got ready=%b mepc=%h mcause=%h want 1/80000300/b", bus.req_ready, csr_file[2], csr_file[3]); end
    endtask

    initial begin
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_csr    = 12'h0;
        bus.req_src    = 64'h0;
        bus.req_pc     = 64'h0;
        bus.resp_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_csrrw();
        test_set_clear();
        test_ecall();
        test_mret();
        test_illegal();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
